// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the serial pattern detector
package seq_det_pkg;
  localparam int DEF_CNT_W = 8;
  localparam bit PAT_MSB_OLDEST = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial input, pattern control and status bundle of seq_det_n
interface seq_det_if import seq_det_pkg::*; #(
  parameter int N = 2,
  parameter int CNT_W = DEF_CNT_W
);
  logic x, x_valid, overlap, pat_load, cnt_clr;
  logic [N-1:0] pat_in;
  logic det, det_q;
  logic [CNT_W-1:0] match_cnt;
  logic [N-1:0] pat;
  modport master (output x, x_valid, overlap, pat_load, pat_in, cnt_clr, input det, det_q, match_cnt, pat);
  modport slave (input x, x_valid, overlap, pat_load, pat_in, cnt_clr, output det, det_q, match_cnt, pat);
endinterface

// File: rtl/seq_det_sat_cnt.sv
// sat_cnt: saturating up-counter; clear together with increment yields 1
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr ? {{(W-1){1'b0}}, inc} : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/seq_det_n.sv
// seq_det_n: runtime-loadable N-bit serial pattern detector with Mealy and registered match
module seq_det_n import seq_det_pkg::*; #(
  parameter int N = 2,
  parameter logic [N-1:0] PAT_RST = {N{1'b1}},
  parameter int CNT_W = DEF_CNT_W
) (
  input logic     clk,
  input logic     rst,
  seq_det_if.slave bus
);
  localparam int FW = clog2(N);
  localparam logic [FW-1:0] FULL = FW'(N - 1);
  if (N < 2) begin : g_bad_n
    $error("seq_det_n: N must be at least 2");
  end
  logic [N-1:0] pat_q, pat_d, win;
  logic [N-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic det, det_q, clear;
  always_comb begin
    win = {hist_q, bus.x};
    det = !rst && !bus.pat_load && bus.x_valid && fill_q == FULL && win == pat_q;
    // a non-overlapping match restarts the search from an empty history
    clear = bus.pat_load || (det && !bus.overlap);
    pat_d = bus.pat_load ? bus.pat_in : pat_q;
    hist_d = clear ? '0 : bus.x_valid ? win[N-2:0] : hist_q;
    fill_d = clear ? '0 : (bus.x_valid && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pat_q <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      det_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q <= det;
    end
  sat_cnt #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (det),
    .clr (bus.cnt_clr),
    .cnt (bus.match_cnt)
  );
  assign bus.det = det;
  assign bus.det_q = det_q;
  assign bus.pat = pat_q;
endmodule

// File: tb/tb_seq_det_n.sv
// tb_seq_det_n: directed scenarios plus randomized run against a bit-history reference model
module tb_seq_det_n;
  logic clk, rst;
  seq_det_if #(.N(2), .CNT_W(2)) a_if ();
  seq_det_if #(.N(4), .CNT_W(8)) b_if ();
  seq_det_n #(.N(2), .PAT_RST(2'b11), .CNT_W(2)) ua (.clk(clk), .rst(rst), .bus(a_if));
  seq_det_n #(.N(4), .PAT_RST(4'b1111), .CNT_W(8)) ub (.clk(clk), .rst(rst), .bus(b_if));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int nn[2] = '{2, 4};
  int maxc[2] = '{3, 255};
  int prst[2] = '{3, 15};
  bit hq[2][$];
  int patm[2], cnt[2];
  bit ed[2];
  logic od[2], odq[2];
  int ocnt[2], opat[2];
  // expected det: the last N-1 accepted bits since the last clear, followed by x, equal the pattern
  function automatic bit model_det(input int k, input bit xi, input bit xv, input bit pl, input bit r);
    int v, s;
    v = 0;
    s = hq[k].size();
    if (r || pl || !xv || s < nn[k] - 1) return 1'b0;
    for (int i = s - (nn[k] - 1); i < s; i++) v = (v << 1) | int'(hq[k][i]);
    v = (v << 1) | int'(xi);
    return v == patm[k];
  endfunction
  task automatic cycle(input bit xi, input bit xv, input bit ov, input bit pla, input bit plb,
                       input bit [1:0] pia, input bit [3:0] pib, input bit clr, input bit r);
    bit pl;
    int pin;
    rst = r;
    a_if.x = xi; b_if.x = xi;
    a_if.x_valid = xv; b_if.x_valid = xv;
    a_if.overlap = ov; b_if.overlap = ov;
    a_if.cnt_clr = clr; b_if.cnt_clr = clr;
    a_if.pat_load = pla; b_if.pat_load = plb;
    a_if.pat_in = pia; b_if.pat_in = pib;
    #1;
    for (int k = 0; k < 2; k++) ed[k] = model_det(k, xi, xv, k ? plb : pla, r);
    od[0] = a_if.det; od[1] = b_if.det;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      pl = k ? plb : pla;
      pin = k ? int'(pib) : int'(pia);
      if (r) begin
        hq[k].delete();
        patm[k] = prst[k];
        cnt[k] = 0;
      end else begin
        if (clr) cnt[k] = ed[k] ? 1 : 0;
        else if (ed[k] && cnt[k] < maxc[k]) cnt[k]++;
        if (pl) begin
          patm[k] = pin;
          hq[k].delete();
        end else if (xv) begin
          if (ed[k] && !ov) hq[k].delete();
          else begin
            hq[k].push_back(xi);
            if (hq[k].size() > nn[k] - 1) void'(hq[k].pop_front());
          end
        end
      end
    end
    #1;
    odq[0] = a_if.det_q; odq[1] = b_if.det_q;
    ocnt[0] = int'(a_if.match_cnt); ocnt[1] = int'(b_if.match_cnt);
    opat[0] = int'(a_if.pat); opat[1] = int'(b_if.pat);
  endtask
  task automatic test_reset;
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++; if (od[k] !== 1'b0) begin bad++; $display("FAIL reset_det[%0d]: got %b want 0", k, od[k]); end
      total++; if (odq[k] !== 1'b0) begin bad++; $display("FAIL reset_det_q[%0d]: got %b want 0", k, odq[k]); end
      total++; if (ocnt[k] !== 0) begin bad++; $display("FAIL reset_cnt[%0d]: got %0d want 0", k, ocnt[k]); end
      total++; if (opat[k] !== prst[k]) begin bad++; $display("FAIL reset_pat[%0d]: got %0d want %0d", k, opat[k], prst[k]); end
    end
  endtask
  task automatic test_overlap;
    bit xs[6] = '{1, 1, 1, 0, 1, 1};
    bit es[6] = '{0, 1, 1, 0, 0, 1};
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(xs[i], 1, 1, 0, 0, 0, 0, 0, 0);
      total++; if (od[0] !== es[i]) begin bad++; $display("FAIL ovl_det bit%0d: got %b want %b", i + 1, od[0], es[i]); end
      total++; if (odq[0] !== es[i]) begin bad++; $display("FAIL ovl_det_q bit%0d: got %b want %b", i + 1, odq[0], es[i]); end
    end
    total++; if (ocnt[0] !== 3) begin bad++; $display("FAIL ovl_cnt: got %0d want 3", ocnt[0]); end
  endtask
  task automatic test_nonoverlap;
    bit es[4] = '{0, 1, 0, 1};
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      total++; if (od[0] !== es[i]) begin bad++; $display("FAIL novl_det bit%0d: got %b want %b", i + 1, od[0], es[i]); end
    end
    total++; if (ocnt[0] !== 2) begin bad++; $display("FAIL novl_cnt: got %0d want 2", ocnt[0]); end
  endtask
  task automatic test_load;
    bit xs[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit es[7] = '{0, 0, 0, 1, 0, 0, 1};
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 1, 0, 4'b1011, 0, 0);
    total++; if (od[1] !== 1'b0) begin bad++; $display("FAIL load_det: got %b want 0", od[1]); end
    for (int i = 0; i < 7; i++) begin
      cycle(xs[i], 1, 1, 0, 0, 0, 0, 0, 0);
      total++; if (od[1] !== es[i]) begin bad++; $display("FAIL load_det bit%0d: got %b want %b", i + 1, od[1], es[i]); end
    end
    total++; if (opat[1] !== 11) begin bad++; $display("FAIL load_pat: got %0d want 11", opat[1]); end
    total++; if (ocnt[1] !== 2) begin bad++; $display("FAIL load_cnt: got %0d want 2", ocnt[1]); end
  endtask
  task automatic test_gap;
    bit xs[3] = '{1, 0, 1};
    bit es[3] = '{0, 0, 1};
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(xs[i], xs[i], 1, 0, 0, 0, 0, 0, 0);
      total++; if (od[0] !== es[i]) begin bad++; $display("FAIL gap_det cyc%0d: got %b want %b", i + 1, od[0], es[i]); end
    end
  endtask
  task automatic test_reset_mid;
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 1);
    total++; if (od[0] !== 1'b0) begin bad++; $display("FAIL rstmid_det_in_rst: got %b want 0", od[0]); end
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    total++; if (od[0] !== 1'b0) begin bad++; $display("FAIL rstmid_det_first: got %b want 0", od[0]); end
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    total++; if (od[0] !== 1'b1) begin bad++; $display("FAIL rstmid_det_second: got %b want 1", od[0]); end
  endtask
  task automatic test_saturate;
    int ec[5] = '{1, 2, 3, 3, 3};
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
      total++; if (ocnt[0] !== ec[i]) begin bad++; $display("FAIL sat_cnt match%0d: got %0d want %0d", i + 1, ocnt[0], ec[i]); end
    end
    cycle(1, 1, 1, 0, 0, 0, 0, 1, 0);
    total++; if (od[0] !== 1'b1) begin bad++; $display("FAIL sat_clr_det: got %b want 1", od[0]); end
    total++; if (ocnt[0] !== 1) begin bad++; $display("FAIL sat_clr_cnt: got %0d want 1", ocnt[0]); end
    cycle(0, 0, 1, 0, 0, 0, 0, 1, 0);
    total++; if (ocnt[0] !== 0) begin bad++; $display("FAIL sat_clr_idle: got %0d want 0", ocnt[0]); end
  endtask
  task automatic test_random;
    bit xi, xv, ov, pla, plb, clr, r;
    bit [1:0] pia;
    bit [3:0] pib;
    bit prev[2];
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      xi = 1'($urandom);
      xv = $urandom_range(0, 3) != 0;
      ov = 1'($urandom);
      pla = $urandom_range(0, 29) == 0;
      plb = $urandom_range(0, 29) == 0;
      pia = 2'($urandom);
      pib = 4'($urandom);
      clr = $urandom_range(0, 24) == 0;
      r = $urandom_range(0, 99) == 0;
      cycle(xi, xv, ov, pla, plb, pia, pib, clr, r);
      for (int k = 0; k < 2; k++) begin
        prev[k] = ed[k];
        total++; if (od[k] !== ed[k]) begin bad++; $display("FAIL rnd_det[%0d] n=%0d: got %b want %b", k, n, od[k], ed[k]); end
        total++; if (odq[k] !== prev[k]) begin bad++; $display("FAIL rnd_det_q[%0d] n=%0d: got %b want %b", k, n, odq[k], prev[k]); end
        total++; if (ocnt[k] !== cnt[k]) begin bad++; $display("FAIL rnd_cnt[%0d] n=%0d: got %0d want %0d", k, n, ocnt[k], cnt[k]); end
        total++; if (opat[k] !== patm[k]) begin bad++; $display("FAIL rnd_pat[%0d] n=%0d: got %0d want %0d", k, n, opat[k], patm[k]); end
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_load;
    test_gap;
    test_reset_mid;
    test_saturate;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
